// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the fetch-stage program-counter generator.
package pc_gen_pkg;

    localparam logic [31:0] BASE_PC      = 32'h0000_0000;
    localparam int unsigned PC_STEP      = 4;
    localparam int unsigned HOLD_CODE_PC = 1;
    localparam logic [31:0] BUS_ADDR_MEM = 32'h0000_0000;

    // Source of the next fetch address on an accepted fetch.
    typedef enum logic [1:0] {
        SRC_SEQ,
        SRC_NEW,
        SRC_PEND
    } pc_src_e;

endpackage

// File: rtl/pc_gen_redir_arb.sv
// Combinational priority encoder over redirect channels; channel 0 wins.
module pc_redir_arb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned N_REDIR = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [N_REDIR-1:0]        redir_vld,
    input  logic [N_REDIR*ADDR_W-1:0] redir_pc,
    output logic                      hit,
    output logic [IDX_W-1:0]          sel,
    output logic [ADDR_W-1:0]         tgt
);

    always_comb begin
        hit = 1'b0;
        sel = '0;
        tgt = '0;
        for (int unsigned i = 0; i < N_REDIR; i++) begin
            if (redir_vld[i] && !hit) begin
                hit = 1'b1;
                sel = IDX_W'(i);
                tgt = redir_pc[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: sequential advance, prioritised redirects, and a
// single pending slot so redirects raised while stalled are not lost.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = BASE_PC,
    parameter int unsigned       STEP     = PC_STEP,
    parameter int unsigned       N_REDIR  = 3,
    parameter int unsigned       HOLD_W   = 3,
    parameter int unsigned       HOLD_LVL = HOLD_CODE_PC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [HOLD_W-1:0]         hold_code,
    input  logic                      fetch_rdy,
    input  logic [N_REDIR-1:0]        redir_vld,
    input  logic [N_REDIR*ADDR_W-1:0] redir_pc,
    output logic [ADDR_W-1:0]         fetch_pc,
    output logic                      fetch_vld,
    output logic                      redir_taken,
    output logic                      redir_pend,
    output logic                      misalign
);

    localparam int unsigned       IDX_W      = (N_REDIR > 1) ? $clog2(N_REDIR) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));

    logic              arb_hit;
    logic [IDX_W-1:0]  arb_sel;
    logic [ADDR_W-1:0] arb_tgt;

    logic              vld_en;
    logic              pend_v;
    logic [IDX_W-1:0]  pend_idx;
    logic [ADDR_W-1:0] pend_pc;

    logic              stall;
    logic              adv;
    logic              take_new;
    pc_src_e           src;
    logic [ADDR_W-1:0] raw_tgt;

    pc_redir_arb #(
        .ADDR_W  (ADDR_W),
        .N_REDIR (N_REDIR),
        .IDX_W   (IDX_W)
    ) u_arb (
        .redir_vld (redir_vld),
        .redir_pc  (redir_pc),
        .hit       (arb_hit),
        .sel       (arb_sel),
        .tgt       (arb_tgt)
    );

    assign stall      = (hold_code >= HOLD_W'(HOLD_LVL));
    assign fetch_vld  = vld_en & ~stall;
    assign adv        = ~stall & fetch_rdy & fetch_vld;
    assign redir_pend = pend_v;

    // A new redirect beats the pending one only if it is at least as urgent;
    // the same condition decides whether it overwrites the pending slot.
    assign take_new = arb_hit & (~pend_v | (arb_sel <= pend_idx));

    always_comb begin
        src     = SRC_SEQ;
        raw_tgt = pend_pc;
        if (take_new) begin
            src     = SRC_NEW;
            raw_tgt = arb_tgt;
        end else if (pend_v) begin
            src     = SRC_PEND;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_en      <= 1'b0;
            fetch_pc    <= RESET_PC;
            redir_taken <= 1'b0;
            misalign    <= 1'b0;
            pend_v      <= 1'b0;
            pend_idx    <= '0;
            pend_pc     <= '0;
        end else begin
            vld_en <= 1'b1;
            if (adv) begin
                pend_v      <= 1'b0;
                redir_taken <= (src != SRC_SEQ);
                misalign    <= (src != SRC_SEQ) && |(raw_tgt & ~ALIGN_MASK);
                fetch_pc    <= (src == SRC_SEQ) ? fetch_pc + ADDR_W'(STEP)
                                                : raw_tgt & ALIGN_MASK;
            end else begin
                redir_taken <= 1'b0;
                misalign    <= 1'b0;
                if (take_new) begin
                    pend_v   <= 1'b1;
                    pend_idx <= arb_sel;
                    pend_pc  <= arb_tgt;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed vector bench for pc_gen.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  hold_code;
    logic        fetch_rdy;
    logic [2:0]  redir_vld;
    logic [31:0] p0, p1, p2;
    logic [95:0] redir_pc;
    logic [31:0] fetch_pc;
    logic        fetch_vld, redir_taken, redir_pend, misalign;

    int checks   = 0;
    int failures = 0;

    assign redir_pc = {p2, p1, p0};

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .STEP     (4),
        .N_REDIR  (3),
        .HOLD_W   (3),
        .HOLD_LVL (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold_code   (hold_code),
        .fetch_rdy   (fetch_rdy),
        .redir_vld   (redir_vld),
        .redir_pc    (redir_pc),
        .fetch_pc    (fetch_pc),
        .fetch_vld   (fetch_vld),
        .redir_taken (redir_taken),
        .redir_pend  (redir_pend),
        .misalign    (misalign)
    );

    typedef struct {
        logic [2:0]  hold;
        logic        rdy;
        logic [2:0]  vld;
        logic [31:0] t0, t1, t2;
        logic [31:0] e_pc;
        logic        e_tk, e_pd, e_mis, e_fv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] hold, logic rdy, logic [2:0] vld,
                                logic [31:0] t0, logic [31:0] t1, logic [31:0] t2,
                                logic [31:0] e_pc, logic e_tk, logic e_pd,
                                logic e_mis, logic e_fv);
        vec_t v;
        v.hold = hold; v.rdy = rdy; v.vld = vld;
        v.t0 = t0; v.t1 = t1; v.t2 = t2;
        v.e_pc = e_pc; v.e_tk = e_tk; v.e_pd = e_pd; v.e_mis = e_mis; v.e_fv = e_fv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_tk,
                             input logic e_pd, input logic e_mis, input logic e_fv);
        chk({tag, "_pc"},   fetch_pc,           e_pc);
        chk({tag, "_tk"},   {31'd0, redir_taken}, {31'd0, e_tk});
        chk({tag, "_pend"}, {31'd0, redir_pend},  {31'd0, e_pd});
        chk({tag, "_mis"},  {31'd0, misalign},    {31'd0, e_mis});
        chk({tag, "_fvld"}, {31'd0, fetch_vld},   {31'd0, e_fv});
    endtask

    initial begin
        //              hold rdy vld     ch0           ch1           ch2           pc            tk pd ms fv
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h0,        0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h4,        0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h8,        0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3'b110, 0,            32'h100,      32'h200,      32'h100,      1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h104,      0, 0, 0, 1));
        vecs.push_back(mk(2, 1, 3'b100, 0,            0,            32'h300,      32'h104,      0, 1, 0, 0));
        vecs.push_back(mk(2, 1, 3'b000, 0,            0,            0,            32'h104,      0, 1, 0, 0));
        vecs.push_back(mk(2, 1, 3'b000, 0,            0,            0,            32'h104,      0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h300,      1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 3'b100, 0,            0,            32'h300,      32'h300,      0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 3'b001, 32'h80,       0,            0,            32'h300,      0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h80,       1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 3'b001, 32'h40,       0,            0,            32'h80,       0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 3'b100, 0,            0,            32'h500,      32'h80,       0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h40,       1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 3'b010, 0,            32'h600,      0,            32'h40,       0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 3'b100, 0,            0,            32'h700,      32'h600,      1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3'b001, 32'hFFFF_FFFC, 0,           0,            32'hFFFF_FFFC, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h0,        0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3'b010, 0,            32'h103,      0,            32'h100,      1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h104,      0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 3'b100, 0,            0,            32'h20A,      32'h104,      0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h208,      1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 3'b000, 0,            0,            0,            32'h208,      0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b000, 0,            0,            0,            32'h20C,      0, 0, 0, 1));

        rst_n = 1'b0; hold_code = '0; fetch_rdy = 1'b1; redir_vld = '0;
        p0 = '0; p1 = '0; p2 = '0;
        #2;
        check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("reset_hold", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            hold_code = vecs[i].hold;
            fetch_rdy = vecs[i].rdy;
            redir_vld = vecs[i].vld;
            p0 = vecs[i].t0; p1 = vecs[i].t1; p2 = vecs[i].t2;
            step();
            check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_tk,
                      vecs[i].e_pd, vecs[i].e_mis, vecs[i].e_fv);
        end

        // Asynchronous reset with a redirect pending: pc and pending slot clear at once.
        hold_code = '0; fetch_rdy = 1'b0; redir_vld = 3'b001; p0 = 32'h900; p1 = '0; p2 = '0;
        step();
        check_all("pre_rst", 32'h20C, 1'b0, 1'b1, 1'b0, 1'b1);
        redir_vld = '0; fetch_rdy = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_all("post_rst0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_all("post_rst1", 32'h4, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
